// File: rtl/chs_multizone_ctrl.sv
// Multi-zone cool/heat controller: per-zone hysteretic HEAT/COOL/IDLE FSM,
// rate-limited power output and glitch-free PWM fan drive.
module chs_multizone_ctrl #(
   parameter int unsigned ZONES    = 2,
   parameter int unsigned TW       = 8,
   parameter int unsigned PW       = 4,
   parameter int unsigned DW       = 8,
   parameter int unsigned HYST     = 2,
   parameter int unsigned RAMP_DIV = 16
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic [ZONES-1:0]      enable,
   input  logic [ZONES*TW-1:0]   temp,
   input  logic [ZONES*TW-1:0]   setpoint,
   input  logic [ZONES*DW-1:0]   speed,
   output logic [ZONES*PW-1:0]   chs_power,
   output logic [ZONES-1:0]      chs_mode,
   output logic [ZONES-1:0]      chs_active,
   output logic [ZONES-1:0]      pwm_data
);

   localparam int unsigned CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int unsigned XW = TW + 1;
   localparam logic [PW-1:0] PMAX     = '1;
   localparam logic [CW-1:0] PRE_LAST = CW'(RAMP_DIV - 1);
   localparam logic [DW-1:0] CNT_LAST = '1;

   typedef enum logic [1:0] {IDLE, HEAT, COOL} state_t;

   logic [CW-1:0] prescale;
   logic [DW-1:0] pwm_cnt;
   logic          tick_c;
   logic          period_end_c;

   assign tick_c       = (prescale == PRE_LAST);
   assign period_end_c = (pwm_cnt == CNT_LAST);

   // Shared ramp prescaler and free-running PWM counter
   always_ff @(posedge clk) begin
      if (arst) begin
         prescale <= '0;
         pwm_cnt  <= '0;
      end else begin
         prescale <= tick_c ? '0 : prescale + CW'(1);
         pwm_cnt  <= pwm_cnt + DW'(1);
      end
   end

   for (genvar i = 0; i < ZONES; i++) begin : gen_zone
      state_t        state, state_nx;
      logic [XW-1:0] t_x, s_x;
      logic          heat_req, cool_req;
      logic [TW-1:0] diff;
      logic [PW-1:0] target, power_nx, power_q;
      logic          mode_nx, mode_q, active_q, pwm_q;
      logic [DW-1:0] duty;

      assign t_x      = XW'(temp[i*TW +: TW]);
      assign s_x      = XW'(setpoint[i*TW +: TW]);
      assign heat_req = s_x > (t_x + XW'(HYST));
      assign cool_req = t_x > (s_x + XW'(HYST));
      assign diff     = (t_x > s_x) ? TW'(t_x - s_x) : TW'(s_x - t_x);

      // Next state; a new active mode is only entered once power has drained to 0
      always_comb begin
         state_nx = state;
         mode_nx  = mode_q;
         if (!enable[i]) begin
            state_nx = IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (power_q == '0) begin
                     if (heat_req) begin
                        state_nx = HEAT;
                        mode_nx  = 1'b1;
                     end else if (cool_req) begin
                        state_nx = COOL;
                        mode_nx  = 1'b0;
                     end
                  end
               end
               HEAT:    if (t_x >= s_x) state_nx = IDLE;
               COOL:    if (t_x <= s_x) state_nx = IDLE;
               default: state_nx = IDLE;
            endcase
         end
      end

      // Target power and one-step ramp toward it on each prescaler tick
      always_comb begin
         target   = '0;
         power_nx = power_q;
         if (state != IDLE) begin
            target = (diff > TW'(PMAX)) ? PMAX : PW'(diff);
         end
         if (tick_c) begin
            if (power_q < target)      power_nx = power_q + PW'(1);
            else if (power_q > target) power_nx = power_q - PW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (arst) begin
            state    <= IDLE;
            mode_q   <= 1'b0;
            active_q <= 1'b0;
            power_q  <= '0;
            duty     <= '0;
            pwm_q    <= 1'b0;
         end else begin
            state    <= state_nx;
            mode_q   <= mode_nx;
            active_q <= (state_nx != IDLE);
            power_q  <= power_nx;
            if (period_end_c) duty <= speed[i*DW +: DW];
            pwm_q    <= enable[i] && (pwm_cnt < duty);
         end
      end

      assign chs_power[i*PW +: PW] = power_q;
      assign chs_mode[i]           = mode_q;
      assign chs_active[i]         = active_q;
      assign pwm_data[i]           = pwm_q;
   end

endmodule

// File: tb/tb_chs_multizone_ctrl.sv
// Self-checking bench for chs_multizone_ctrl: vector table for FSM/ramp timing
// plus a hand-written PWM period sequence, both via scoreboard queues.
module tb_chs_multizone_ctrl;

   logic        clk = 1'b0;
   logic        arst;
   logic [1:0]  enable;
   logic [15:0] temp, setpoint, speed;
   logic [7:0]  chs_power;
   logic [1:0]  chs_mode, chs_active, pwm_data;

   always #5 clk = ~clk;

   chs_multizone_ctrl #(
      .ZONES(2), .TW(8), .PW(4), .DW(8), .HYST(2), .RAMP_DIV(4)
   ) dut (
      .clk(clk), .arst(arst), .enable(enable), .temp(temp),
      .setpoint(setpoint), .speed(speed), .chs_power(chs_power),
      .chs_mode(chs_mode), .chs_active(chs_active), .pwm_data(pwm_data)
   );

   typedef struct {
      logic       rst;
      logic [1:0] en;
      logic [7:0] t0, s0, t1, s1;
      int         waitn;
      logic [3:0] p0, p1;
      logic [1:0] mode, active;
   } vec_t;

   typedef struct {
      logic [3:0] p0, p1;
      logic [1:0] mode, active, pwm;
   } exp_t;

   exp_t sb[$];
   int   cnt_sb[$];
   int   errors = 0;
   int   checks = 0;
   vec_t v[25];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic compare_outputs(input string tag, input exp_t e, input bit with_pwm);
      check({tag, ".p0"}, 32'(chs_power[3:0]), 32'(e.p0));
      check({tag, ".p1"}, 32'(chs_power[7:4]), 32'(e.p1));
      check({tag, ".mode"}, 32'(chs_mode), 32'(e.mode));
      check({tag, ".active"}, 32'(chs_active), 32'(e.active));
      if (with_pwm) check({tag, ".pwm"}, 32'(pwm_data), 32'(e.pwm));
   endtask

   task automatic count_high(input int n, inout int c0, inout int c1);
      repeat (n) begin
         step(1);
         c0 += int'(pwm_data[0]);
         c1 += int'(pwm_data[1]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   c0, c1, x0, x1;
      logic prev;
      bit   found;

      //       rst en     t0  s0  t1  s1  wait p0 p1 mode   active
      v[0]  = '{1, 2'b11, 23, 25, 60, 25, 1,   0, 0, 2'b00, 2'b00};
      v[1]  = '{0, 2'b11, 23, 25, 60, 25, 1,   0, 0, 2'b00, 2'b10};
      v[2]  = '{0, 2'b11, 22, 25, 60, 25, 1,   0, 0, 2'b01, 2'b11};
      v[3]  = '{0, 2'b11, 22, 25, 60, 25, 1,   0, 0, 2'b01, 2'b11};
      v[4]  = '{0, 2'b11, 22, 25, 60, 25, 1,   1, 1, 2'b01, 2'b11};
      v[5]  = '{0, 2'b11, 22, 25, 60, 25, 4,   2, 2, 2'b01, 2'b11};
      v[6]  = '{0, 2'b11, 22, 25, 60, 25, 4,   3, 3, 2'b01, 2'b11};
      v[7]  = '{0, 2'b11, 22, 25, 60, 25, 8,   3, 5, 2'b01, 2'b11};
      v[8]  = '{0, 2'b11, 30, 25, 60, 25, 1,   3, 5, 2'b01, 2'b10};
      v[9]  = '{0, 2'b11, 30, 25, 60, 25, 3,   2, 6, 2'b01, 2'b10};
      v[10] = '{0, 2'b11, 30, 25, 60, 25, 8,   0, 8, 2'b01, 2'b10};
      v[11] = '{0, 2'b11, 30, 25, 60, 25, 1,   0, 8, 2'b00, 2'b11};
      v[12] = '{0, 2'b11, 30, 25, 60, 25, 3,   1, 9, 2'b00, 2'b11};
      v[13] = '{0, 2'b11, 30, 25, 60, 25, 16,  5, 13, 2'b00, 2'b11};
      v[14] = '{0, 2'b11, 30, 25, 60, 25, 28,  5, 15, 2'b00, 2'b11};
      v[15] = '{0, 2'b10, 30, 25, 60, 25, 1,   5, 15, 2'b00, 2'b10};
      v[16] = '{0, 2'b10, 30, 25, 60, 25, 3,   4, 15, 2'b00, 2'b10};
      v[17] = '{0, 2'b10, 30, 25, 60, 25, 20,  0, 15, 2'b00, 2'b10};
      v[18] = '{0, 2'b11, 30, 25, 60, 25, 1,   0, 15, 2'b00, 2'b11};
      v[19] = '{0, 2'b11, 30, 25, 60, 25, 3,   1, 15, 2'b00, 2'b11};
      v[20] = '{0, 2'b11, 30, 25, 60, 25, 1,   1, 15, 2'b00, 2'b11};
      v[21] = '{1, 2'b11, 30, 25, 60, 25, 1,   0, 0, 2'b00, 2'b00};
      v[22] = '{0, 2'b11, 30, 25, 60, 25, 1,   0, 0, 2'b00, 2'b11};
      v[23] = '{0, 2'b11, 30, 25, 60, 25, 2,   0, 0, 2'b00, 2'b11};
      v[24] = '{0, 2'b11, 30, 25, 60, 25, 1,   1, 1, 2'b00, 2'b11};

      speed = '0;
      for (int i = 0; i < 25; i++) begin
         arst     = v[i].rst;
         enable   = v[i].en;
         temp     = {v[i].t1, v[i].t0};
         setpoint = {v[i].s1, v[i].s0};
         sb.push_back('{v[i].p0, v[i].p1, v[i].mode, v[i].active, 2'b00});
         step(v[i].waitn);
         e = sb.pop_front();
         compare_outputs($sformatf("vec%0d", i), e, 1'b1);
      end

      // PWM: both zones saturated; zone0 duty 200, zone1 duty 64
      speed = {8'd64, 8'd200};
      sb.push_back('{4'd5, 4'd15, 2'b00, 2'b11, 2'b00});
      step(300);
      e = sb.pop_front();
      compare_outputs("pre_pwm", e, 1'b0);

      found = 1'b0;
      prev  = pwm_data[1];
      for (int k = 0; k < 600 && !found; k++) begin
         step(1);
         if (pwm_data[1] && !prev) found = 1'b1;
         else prev = pwm_data[1];
      end
      check("pwm1_rise_seen", 32'(found), 32'd1);

      if (found) begin
         // Period A: speed1 changed mid-period, old duty still applies
         speed[15:8] = 8'd128;
         cnt_sb.push_back(200);
         cnt_sb.push_back(64);
         c0 = int'(pwm_data[0]);
         c1 = int'(pwm_data[1]);
         count_high(255, c0, c1);
         x0 = cnt_sb.pop_front();
         x1 = cnt_sb.pop_front();
         check("periodA.pwm0", 32'(c0), 32'(x0));
         check("periodA.pwm1", 32'(c1), 32'(x1));

         // Period B: zone0 disabled, zone1 at new duty 128
         enable      = 2'b10;
         speed[15:8] = 8'd0;
         cnt_sb.push_back(0);
         cnt_sb.push_back(128);
         c0 = 0;
         c1 = 0;
         count_high(256, c0, c1);
         x0 = cnt_sb.pop_front();
         x1 = cnt_sb.pop_front();
         check("periodB.pwm0", 32'(c0), 32'(x0));
         check("periodB.pwm1", 32'(c1), 32'(x1));

         // Period C: zone1 duty 0 is constantly low
         cnt_sb.push_back(0);
         cnt_sb.push_back(0);
         c0 = 0;
         c1 = 0;
         count_high(256, c0, c1);
         x0 = cnt_sb.pop_front();
         x1 = cnt_sb.pop_front();
         check("periodC.pwm0", 32'(c0), 32'(x0));
         check("periodC.pwm1", 32'(c1), 32'(x1));

         sb.push_back('{4'd0, 4'd15, 2'b00, 2'b10, 2'b00});
         e = sb.pop_front();
         compare_outputs("post_pwm", e, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
